// File: rtl/morse_key_encoder.sv
// morse_key_encoder: turns a raw Morse key into up to five dot/dash symbol
// slots per letter, with a one-cycle letter_done pulse once the key has been
// released long enough to end the letter.
// Optional build macro KEY_DEBOUNCE_EN adds a stability filter after the
// synchronizer; without it the synchronizer output is used directly.
module morse_key_encoder #(
  parameter int DOT_MAX_CYCLES  = 20000000,
  parameter int GAP_CYCLES      = 60000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [1:0] morse_one,
  output logic [1:0] morse_two,
  output logic [1:0] morse_three,
  output logic [1:0] morse_four,
  output logic [1:0] morse_five,
  output logic       letter_done,
  output logic [2:0] symbol_count,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DOT_C    = CNT_W'(DOT_MAX_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  logic [1:0] sync_q, sync_d;
  logic       key_s;

  assign sync_d = {sync_q[0], key};

  // two-flop synchronizer for the asynchronous key
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

`ifdef KEY_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_f_q, key_f_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  // filtered key flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    key_f_d  = key_f_q;
    db_cnt_d = '0;
    if (sync_q[1] != key_f_q) begin
      if (db_cnt_q >= DB_LAST) key_f_d  = sync_q[1];
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // debounce state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      key_f_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      key_f_q  <= key_f_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign key_s = key_f_q;
`else
  assign key_s = sync_q[1];
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] press_q, press_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic [4:0][1:0]  slot_q, slot_d;
  logic [2:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [1:0]       sym;

  // next-state logic: press timing, symbol capture, letter gap detection
  always_comb begin
    state_d = state_q;
    press_d = press_q;
    rel_d   = rel_q;
    slot_d  = slot_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    // press_q is one less than the press length, so L <= DOT_MAX is press_q < DOT_MAX
    sym     = (press_q < DOT_C) ? 2'b01 : 2'b10;
    case (state_q)
      IDLE: begin
        // previous letter stays visible here until a new press starts
        if (key_s) begin
          slot_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          press_d = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (key_s) begin
          if (press_q != CNT_MAX) press_d = press_q + 1'b1;
        end else begin
          if (count_q == 3'd5) begin
            // sixth symbol: the letter is unusable, blank it and flag it
            slot_d = '0;
            ovf_d  = 1'b1;
          end else begin
            slot_d[count_q] = sym;
            count_d         = count_q + 3'd1;
          end
          rel_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (rel_q >= GAP_C) begin
          // done pulse is high this cycle; hand over to IDLE
          state_d = IDLE;
        end else if (key_s) begin
          press_d = '0;
          state_d = PRESS;
        end else begin
          if (rel_q != CNT_MAX) rel_d = rel_q + 1'b1;
          // registered pulse lines up with the counter reaching GAP_CYCLES
          if (rel_q == GAP_LAST) done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      press_q <= '0;
      rel_q   <= '0;
      slot_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      slot_q  <= slot_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign morse_one    = slot_q[0];
  assign morse_two    = slot_q[1];
  assign morse_three  = slot_q[2];
  assign morse_four   = slot_q[3];
  assign morse_five   = slot_q[4];
  assign letter_done  = done_q;
  assign symbol_count = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_morse_key_encoder.sv
// Bench for morse_key_encoder: directed letters plus random letters, checked
// against a letter-level model (press lengths -> expected slots/count/overflow).
module tb_morse_key_encoder;
  localparam int DOT = 4;
  localparam int GAP = 12;
  localparam int DB  = 3;
  localparam int CW  = 4;   // small so a long press saturates the counter
`ifdef KEY_DEBOUNCE_EN
  localparam int MINL = 4;
`else
  localparam int MINL = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic [1:0] morse_one, morse_two, morse_three, morse_four, morse_five;
  logic       letter_done;
  logic [2:0] symbol_count;
  logic       overflow;

  always #5 clk = ~clk;

  morse_key_encoder #(
    .DOT_MAX_CYCLES (DOT),
    .GAP_CYCLES     (GAP),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key         (key),
    .morse_one   (morse_one),
    .morse_two   (morse_two),
    .morse_three (morse_three),
    .morse_four  (morse_four),
    .morse_five  (morse_five),
    .letter_done (letter_done),
    .symbol_count(symbol_count),
    .overflow    (overflow)
  );

  typedef struct {
    logic [9:0] slots;  // {five,four,three,two,one}
    int         cnt;
    logic       ovf;
  } letter_t;

  int      n_vec = 0;
  int      n_err = 0;
  letter_t exp_q[$];
  int      lq[$];
  int      gq[$];
  logic    prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // letter-level reference: each press length becomes dot/dash, six or more overflow
  function automatic letter_t model(input int lens[$]);
    letter_t    r;
    logic [1:0] code;
    r.slots = '0;
    r.cnt   = 0;
    r.ovf   = 1'b0;
    foreach (lens[i]) begin
      code = (lens[i] > DOT) ? 2'b10 : 2'b01;
      if (r.cnt == 5) begin
        r.slots = '0;
        r.ovf   = 1'b1;
      end else begin
        r.slots[r.cnt*2 +: 2] = code;
        r.cnt++;
      end
    end
    return r;
  endfunction

  function automatic logic [9:0] slots_now();
    return {morse_five, morse_four, morse_three, morse_two, morse_one};
  endfunction

  // every letter_done pulse must match the oldest outstanding letter
  always @(negedge clk) begin
    letter_t e;
    if (letter_done === 1'b1) begin
      chk("done_twice", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("done_unexpected", {31'd0, letter_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_slots", {22'd0, slots_now()}, {22'd0, e.slots});
        chk("done_count", {29'd0, symbol_count}, e.cnt);
        chk("done_ovf",   {31'd0, overflow}, {31'd0, e.ovf});
      end
    end
    prev_done = letter_done;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    key = v;
    repeat (n) tick();
  endtask

  // expect the letter in lq, release the key and confirm it was reported and held
  task automatic finish_letter(input int endgap);
    letter_t e;
    e = model(lq);
    exp_q.push_back(e);
    hold(1'b0, endgap);
    chk("letter_reported", exp_q.size(), 32'd0);
    chk("held_slots", {22'd0, slots_now()}, {22'd0, e.slots});
    chk("held_count", {29'd0, symbol_count}, e.cnt);
    chk("held_ovf",   {31'd0, overflow}, {31'd0, e.ovf});
  endtask

  task automatic send_letter(input int endgap);
    foreach (lq[i]) begin
      hold(1'b1, lq[i]);
      if (i < lq.size() - 1) hold(1'b0, gq[i]);
    end
    finish_letter(endgap);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_slots"}, {22'd0, slots_now()}, 32'd0);
    chk({tag, "_count"}, {29'd0, symbol_count}, 32'd0);
    chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    chk({tag, "_done"},  {31'd0, letter_done}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    key   = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    hold(1'b0, 3);

`ifdef KEY_DEBOUNCE_EN
    // short glitches must never become symbols or letters
    hold(1'b1, 1); hold(1'b0, 25);
    hold(1'b1, 2); hold(1'b0, 25);
    chk("glitch_count", {29'd0, symbol_count}, 32'd0);
    lq = '{10}; gq.delete();
    send_letter(20);
`else
    // symbol appears on the first cycle after the synchronized key drops
    hold(1'b1, 3);
    key = 1'b0;
    tick(); tick();
    chk("sym_not_yet", {29'd0, symbol_count}, 32'd0);
    tick();
    chk("sym_visible_cnt", {29'd0, symbol_count}, 32'd1);
    chk("sym_visible_one", {30'd0, morse_one}, 32'd1);
    lq = '{3};
    finish_letter(20);
`endif

    // dot/dash boundary
    lq = '{4}; gq.delete(); send_letter(20);
    lq = '{5}; send_letter(20);
    // dash, short gap, dot
    lq = '{8, 2}; gq = '{3}; send_letter(20);
    // five dashes
    lq = '{8, 8, 8, 8, 8}; gq = '{3, 3, 3, 3}; send_letter(20);
    // six dots overflow
    lq = '{2, 2, 2, 2, 2, 2}; gq = '{3, 3, 3, 3, 3}; send_letter(20);
    // next press clears overflow and the slots
    key = 1'b1;
    repeat (4) tick();
    chk_all_zero("new_press");
    repeat (2) tick();
    lq = '{6};
    finish_letter(20);
    // held key saturates the press counter and still reads as dash
    lq = '{40}; gq.delete(); send_letter(20);

    // reset during the second press abandons the letter
    hold(1'b1, 8); hold(1'b0, 3);
    key = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    key   = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    hold(1'b0, 25);
    chk("after_reset_count", {29'd0, symbol_count}, 32'd0);
    lq = '{2}; gq.delete(); send_letter(20);

    // random letters
    for (int k = 0; k < 40; k++) begin
      lq.delete();
      gq.delete();
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 7) == 0) lq.push_back(20);
        else                            lq.push_back($urandom_range(MINL, 8));
        if (j < n - 1) gq.push_back($urandom_range(MINL, GAP));
      end
      send_letter($urandom_range(GAP + 8, GAP + 14));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/morse_key_encoder.md
MORSE_KEY_ENCODER -- requirements
Module: morse_key_encoder

Interface
REQ-001 SHALL have parameter DOT_MAX_CYCLES, default 20000000: longest press, in cycles, classified as dot.
REQ-002 SHALL have parameter GAP_CYCLES, default 60000000: release length, in cycles, that ends a letter.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stability window, used only when KEY_DEBOUNCE_EN is defined.
REQ-004 SHALL have parameter CNT_W, default 27: width of the internal duration counters.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge system clock.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port key  input  1  raw asynchronous Morse key, 1 = pressed.
REQ-008 SHALL have ports morse_one..morse_five  output  2 each  symbol slots: 00 empty, 01 dot, 10 dash.
REQ-009 SHALL have port letter_done  output  1  one-cycle pulse marking a completed letter.
REQ-010 SHALL have port symbol_count  output  3  number of symbols captured in the current letter, 0..5.
REQ-011 SHALL have port overflow  output  1  high when more than five symbols were keyed in the current letter.

Function
REQ-012 SHALL pass key through a 2-flop synchronizer; key_s is the result and all timing is measured on key_s.
REQ-013 SHALL implement the states IDLE, PRESS and GAP.
REQ-014 IDLE: on key_s=1, SHALL clear all slots, symbol_count and overflow, zero the press counter, then enter PRESS.
REQ-015 PRESS: press counter SHALL increment by 1 per cycle while key_s=1 and saturate at 2^CNT_W-1.
REQ-016 PRESS, key_s=0: press length L SHALL be classified dot if L<=DOT_MAX_CYCLES, else dash; the classification SHALL be written into slot index symbol_count, symbol_count incremented, release counter zeroed, next state GAP.
REQ-017 A symbol SHALL be visible on its slot output on the first cycle after key_s is first sampled low.
REQ-018 If symbol_count is already 5 at a release, SHALL write no slot, SHALL clear all five slots to 00, SHALL set overflow=1 and SHALL hold symbol_count at 5.
REQ-019 GAP: release counter SHALL increment per cycle while key_s=0 and saturate at its maximum.
REQ-020 GAP: key_s=1 before GAP_CYCLES is reached SHALL re-enter PRESS with the slots kept and the press counter zeroed.
REQ-021 GAP: when the release counter reaches GAP_CYCLES, SHALL pulse letter_done for exactly one cycle and enter IDLE.
REQ-022 Slots, symbol_count and overflow SHALL hold their values in IDLE until the next press, so the downstream decoder sees stable symbols with letter_done.
REQ-023 A key held indefinitely SHALL remain in PRESS; its saturated counter SHALL classify as dash on release.
REQ-024 letter_done SHALL never assert in IDLE or PRESS, and SHALL never assert on two consecutive cycles.

Reset
REQ-025 On reset=1 at a clock edge, SHALL set all slots to 00, letter_done=0, symbol_count=0 and overflow=0.
REQ-026 On reset, SHALL zero both counters and the synchronizer, clear the debounce state, and enter IDLE.
REQ-027 Reset asserted mid-PRESS or mid-GAP SHALL abandon the partial letter with no letter_done pulse.
REQ-028 Reset SHALL take priority over all other events in the same cycle.

Configuration
REQ-029 Macro KEY_DEBOUNCE_EN SHALL select the debounce filter.
REQ-030 With KEY_DEBOUNCE_EN defined, key_s SHALL change only after the synchronized key has differed from key_s for DEBOUNCE_CYCLES consecutive cycles.
REQ-031 With KEY_DEBOUNCE_EN defined, shorter glitches SHALL be ignored and all timing SHALL be measured on the filtered signal.
REQ-032 With KEY_DEBOUNCE_EN undefined, key_s SHALL be the raw synchronizer output, DEBOUNCE_CYCLES SHALL be unused, and no filter logic SHALL be present.

Verification (DOT_MAX_CYCLES=4, GAP_CYCLES=12, DEBOUNCE_CYCLES=3, macro undefined unless stated)
REQ-033 Press 4 cycles, release 20 cycles -> morse_one=01, others 00, symbol_count=1, single letter_done pulse; press 5 cycles -> morse_one=10.
REQ-034 Dash(8), gap 3, dot(2), gap 20 -> morse_one=10, morse_two=01, symbol_count=2, one letter_done pulse, with no pulse at the 3-cycle gap.
REQ-035 Five dashes separated by 3-cycle gaps, then release 20 cycles -> all five slots 10, symbol_count=5, letter_done pulses once.
REQ-036 Six dots -> overflow=1 after the sixth release, all slots 00, letter_done pulses; next press clears overflow.
REQ-037 reset=1 for one cycle mid-PRESS of the second symbol -> all outputs 0 the next cycle, no letter_done; a following dot lands in morse_one.
REQ-038 KEY_DEBOUNCE_EN defined: 1- and 2-cycle key glitches produce no symbol; a 10-cycle press produces morse_one=10.
